// File: rtl/alu_pkg.sv
// Package for the pipelined multi-cycle ALU.
// Holds the 4-bit ALU_control opcode encodings shared with the control unit,
// the handshake FSM state type and the bit positions inside the {N,Z,C,V}
// flag vector.
package alu_pkg;

  // Opcodes (unchanged from the first-generation ALU, plus MUL/LSL/LSR)
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_ORR  = 4'b0100;
  localparam logic [3:0] OP_EOR  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_MOV  = 4'b1101;
  localparam logic [3:0] OP_CBZ  = 4'b0111;
  localparam logic [3:0] OP_CBNZ = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_LSL  = 4'b1110;
  localparam logic [3:0] OP_LSR  = 4'b1111;

  // Handshake FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no result held
    ST_BUSY = 2'd1,  // multiplier iterating
    ST_HOLD = 2'd2   // result held for downstream
  } alu_state_e;

  // Bit positions inside flags[3:0]
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier (unsigned, low WIDTH bits of product).
// start   : load operands and begin; one multiplier bit consumed per cycle
// busy    : iterations in progress
// done    : one-cycle pulse, product valid while done is high (and after)
// product : low WIDTH bits of a*b
// A start loads WIDTH-1 into the counter; WIDTH shift-add steps follow and
// done is registered on the step taken with counter==0.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CNT_W'(WIDTH - 1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/alu_pipe_mc.sv
// Second-generation integer ALU with registered output and valid/ready
// handshake on both sides.
// in_valid/in_ready  : operation accepted on a rising edge with both high;
//                      alu_ctrl, op_a and B (op_b or imm by alusrc) captured then
// out_valid/out_ready: result/flags/br_take/op_err held until out_ready
// flags              : {N,Z,C,V}; br_take for CBZ/CBNZ; op_err for illegal opcodes
// Non-MUL ops complete on the accept edge (1 op/cycle under back-to-back
// handshakes); MUL runs through alu_mul_iter and holds in_ready low.
module alu_pipe_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter bit          MUL_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic             alusrc,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             br_take,
  output logic             op_err
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             br_take_q, br_take_d;
  logic             op_err_q, op_err_d;

  logic [WIDTH-1:0]   b_sel;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               is_mul;

  logic [WIDTH:0]   add_w, sub_w, lsl_w, lsr_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_nz_en, alu_br, alu_err;
  logic [3:0]       alu_flags;

  logic             mul_start, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_prod;
  logic [3:0]       mul_flags;

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & out_ready);
  assign out_valid = (state_q == ST_HOLD);
  assign accept    = in_valid & in_ready;
  assign b_sel     = alusrc ? imm : op_b;
  assign shamt     = b_sel[SHAMT_W-1:0];
  assign is_mul    = MUL_EN && (alu_ctrl == OP_MUL);

  // Single-cycle datapath. Carries come from WIDTH+1-bit arithmetic: SUB
  // adds ~B+1 so the top bit is the no-borrow carry; the shifts extend by
  // one bit on the outgoing side so that bit is the last one shifted out
  // (zero when shamt is 0).
  always_comb begin
    add_w     = {1'b0, op_a} + {1'b0, b_sel};
    sub_w     = {1'b0, op_a} + {1'b0, ~b_sel} + (WIDTH+1)'(1);
    lsl_w     = {1'b0, op_a} << shamt;
    lsr_w     = {op_a, 1'b0} >> shamt;
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_nz_en = 1'b1;
    alu_br    = 1'b0;
    alu_err   = 1'b0;
    case (alu_ctrl)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (op_a[WIDTH-1] == b_sel[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (op_a[WIDTH-1] != b_sel[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND:  alu_res = op_a & b_sel;
      OP_ORR:  alu_res = op_a | b_sel;
      OP_EOR:  alu_res = op_a ^ b_sel;
      OP_NOR:  alu_res = ~(op_a | b_sel);
      OP_NAND: alu_res = ~(op_a & b_sel);
      OP_MOV:  alu_res = b_sel;
      OP_LSL: begin
        alu_res = lsl_w[WIDTH-1:0];
        alu_c   = lsl_w[WIDTH];
      end
      OP_LSR: begin
        alu_res = lsr_w[WIDTH:1];
        alu_c   = lsr_w[0];
      end
      OP_CBZ: begin
        alu_nz_en = 1'b0;
        alu_br    = (b_sel == '0);
      end
      OP_CBNZ: begin
        alu_nz_en = 1'b0;
        alu_br    = (b_sel != '0);
      end
      OP_MUL: begin
        // Implemented multiply is taken from alu_mul_iter; these values
        // only reach the register when MUL is disabled.
        alu_nz_en = 1'b0;
        alu_err   = !MUL_EN;
      end
      default: begin
        alu_nz_en = 1'b0;
        alu_err   = 1'b1;
      end
    endcase

    alu_flags = '0;
    if (alu_nz_en) begin
      alu_flags[FLAG_N] = alu_res[WIDTH-1];
      alu_flags[FLAG_Z] = (alu_res == '0);
      alu_flags[FLAG_C] = alu_c;
      alu_flags[FLAG_V] = alu_v;
    end

    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_prod[WIDTH-1];
    mul_flags[FLAG_Z] = (mul_prod == '0);
  end

  // Next-state / output-register logic. Registers only change on an
  // accept, on multiplier completion or on draining to IDLE, so outputs
  // are stable while out_valid & !out_ready.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    br_take_d = br_take_q;
    op_err_d  = op_err_q;
    mul_start = 1'b0;
    case (state_q)
      ST_BUSY: begin
        if (mul_done && !mul_busy) begin
          state_d   = ST_HOLD;
          result_d  = mul_prod;
          flags_d   = mul_flags;
          br_take_d = 1'b0;
          op_err_d  = 1'b0;
        end
      end
      default: begin
        if (accept) begin
          if (is_mul) begin
            state_d   = ST_BUSY;
            mul_start = 1'b1;
          end else begin
            state_d   = ST_HOLD;
            result_d  = alu_res;
            flags_d   = alu_flags;
            br_take_d = alu_br;
            op_err_d  = alu_err;
          end
        end else if (state_q == ST_HOLD && out_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      flags_q   <= '0;
      br_take_q <= 1'b0;
      op_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      br_take_q <= br_take_d;
      op_err_q  <= op_err_d;
    end
  end

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (op_a),
        .b       (b_sel),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
      );
    end else begin : g_no_mul
      assign mul_busy = 1'b0;
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  assign result  = result_q;
  assign flags   = flags_q;
  assign br_take = br_take_q;
  assign op_err  = op_err_q;

endmodule

// File: tb/tb_alu_pipe_mc.sv
// Bench for alu_pipe_mc (WIDTH=32): directed vectors with hand-computed
// results, a reference model using plain 64-bit arithmetic, an expectation
// queue filled on each accept and a per-cycle compare process.
module tb_alu_pipe_mc;

  localparam logic [3:0] ADD  = 4'b0010, SUB  = 4'b1010, AND_ = 4'b0110,
                         ORR  = 4'b0100, EOR  = 4'b1001, NOR_ = 4'b0101,
                         NAND_= 4'b1100, MOV  = 4'b1101, CBZ  = 4'b0111,
                         CBNZ = 4'b0001, MUL  = 4'b0011, LSL  = 4'b1110,
                         LSR  = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctrl = '0;
  logic        alusrc = 1'b0;
  logic [31:0] op_a = '0, op_b = '0, imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        br_take, op_err;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  fl;
    logic        br;
    logic        err;
  } exp_t;

  typedef struct {
    logic [3:0]  c;
    logic        s;
    logic [31:0] a, b, im, res;
    logic [3:0]  fl;
    logic        br, err;
  } vec_t;

  exp_t expq[$];
  vec_t vq[$];

  alu_pipe_mc #(.WIDTH(32), .SHAMT_W(5), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .alusrc    (alusrc),
    .op_a      (op_a),
    .op_b      (op_b),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .br_take   (br_take),
    .op_err    (op_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: operation semantics from 64-bit integer arithmetic.
  function automatic exp_t ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint unsigned ua, ub, w;
    longint sa, sb, sr;
    int sh;
    bit arith, cf, vf;
    e = '0; ua = a; ub = b; sa = $signed(a); sb = $signed(b); sh = int'(b[4:0]);
    arith = 1; cf = 0; vf = 0; w = 0; sr = 0;
    case (c)
      ADD: begin
        w = ua + ub; e.res = w[31:0]; cf = w[32];
        sr = sa + sb; vf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      SUB: begin
        w = ua - ub; e.res = w[31:0]; cf = (ua >= ub);
        sr = sa - sb; vf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      AND_:  e.res = a & b;
      ORR:   e.res = a | b;
      EOR:   e.res = a ^ b;
      NOR_:  e.res = ~(a | b);
      NAND_: e.res = ~(a & b);
      MOV:   e.res = b;
      MUL:   begin w = ua * ub; e.res = w[31:0]; end
      LSL: begin
        w = ua << sh; e.res = w[31:0];
        cf = (sh == 0) ? 1'b0 : w[32];
      end
      LSR: begin
        e.res = a >> sh;
        cf = (sh == 0) ? 1'b0 : ((ua >> (sh - 1)) & 64'd1) != 0;
      end
      CBZ:  begin arith = 0; e.br = (b == 0); end
      CBNZ: begin arith = 0; e.br = (b != 0); end
      default: begin arith = 0; e.err = 1; end
    endcase
    if (arith) e.fl = {e.res[31], e.res == 0, cf, vf};
    return e;
  endfunction

  task automatic addv(input logic [3:0] c, input logic s, input logic [31:0] a, b, im, res,
                      input logic [3:0] fl, input logic br, err);
    vec_t v;
    v.c = c; v.s = s; v.a = a; v.b = b; v.im = im; v.res = res; v.fl = fl; v.br = br; v.err = err;
    vq.push_back(v);
  endtask

  // Present one op, wait (bounded) for the accept edge, record expectation,
  // then scramble the inputs so late changes would show up as errors.
  task automatic send(input logic [3:0] c, input logic s, input logic [31:0] a, b, im, output int waits);
    waits = 0;
    alu_ctrl = c; alusrc = s; op_a = a; op_b = b; imm = im; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    expq.push_back(ref_alu(c, a, s ? im : b));
    #1;
    in_valid = 1'b0;
    op_a = 32'hDEAD_BEEF; op_b = 32'hCAFE_F00D; imm = 32'h1357_9BDF; alu_ctrl = 4'b1000; alusrc = ~s;
  endtask

  // Compare process: whenever out_valid is high the held outputs must
  // match the oldest outstanding expectation; it retires on out_ready.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        chk("mon_result",  result,  expq[0].res);
        chk("mon_flags",   flags,   expq[0].fl);
        chk("mon_br_take", br_take, expq[0].br);
        chk("mon_op_err",  op_err,  expq[0].err);
        if (out_ready) void'(expq.pop_front());
      end
    end
  end

  initial begin
    int w, k, seen;
    bit prev_mul;
    exp_t e;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready, 1);
    chk("rst_result",    result, 0);
    chk("rst_flags",     flags, 0);
    chk("rst_br_take",   br_take, 0);
    chk("rst_op_err",    op_err, 0);
    @(posedge clk); #1;

    // ADD overflow: result visible right after the accept edge
    send(ADD, 1'b0, 32'h7FFF_FFFF, 32'h1, 32'h0, w);
    chk("add_latency_valid", out_valid, 1);
    chk("add_ovf_result", result, 32'h8000_0000);
    chk("add_ovf_flags", flags, 4'b1001);

    // Directed table: {op, alusrc, A, op_b, imm} -> {result, NZCV, br, err}
    addv(ADD,   0, 32'h7FFF_FFFF, 32'h1,         32'h0,         32'h8000_0000, 4'b1001, 0, 0);
    addv(SUB,   1, 32'h5,         32'hFFFF_0000, 32'h5,         32'h0,         4'b0110, 0, 0);
    addv(SUB,   0, 32'h0,         32'h1,         32'h0,         32'hFFFF_FFFF, 4'b1000, 0, 0);
    addv(SUB,   0, 32'h8000_0000, 32'h1,         32'h0,         32'h7FFF_FFFF, 4'b0011, 0, 0);
    addv(ADD,   0, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,         4'b0110, 0, 0);
    addv(ADD,   0, 32'h8000_0000, 32'h8000_0000, 32'h0,         32'h0,         4'b0111, 0, 0);
    addv(AND_,  0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0,         32'h00F0_00F0, 4'b0000, 0, 0);
    addv(ORR,   0, 32'h0,         32'h0,         32'h0,         32'h0,         4'b0100, 0, 0);
    addv(ORR,   0, 32'h1234_0000, 32'h0000_5678, 32'h0,         32'h1234_5678, 4'b0000, 0, 0);
    addv(EOR,   0, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0,         32'hFFFF_0000, 4'b1000, 0, 0);
    addv(NOR_,  0, 32'h0,         32'h0,         32'h0,         32'hFFFF_FFFF, 4'b1000, 0, 0);
    addv(NAND_, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0,         4'b0100, 0, 0);
    addv(MOV,   1, 32'hAAAA_5555, 32'h1,         32'h1234_5678, 32'h1234_5678, 4'b0000, 0, 0);
    addv(LSL,   0, 32'h1,         32'd31,        32'h0,         32'h8000_0000, 4'b1000, 0, 0);
    addv(LSL,   0, 32'h3,         32'h21,        32'h0,         32'h6,         4'b0000, 0, 0);
    addv(LSL,   0, 32'hC000_0000, 32'h1,         32'h0,         32'h8000_0000, 4'b1010, 0, 0);
    addv(LSR,   0, 32'h8000_0001, 32'h1,         32'h0,         32'h4000_0000, 4'b0010, 0, 0);
    addv(LSR,   0, 32'h5,         32'h0,         32'h0,         32'h5,         4'b0000, 0, 0);
    addv(CBZ,   1, 32'h7,         32'h9,         32'h0,         32'h0,         4'b0000, 1, 0);
    addv(CBNZ,  0, 32'h7,         32'h0,         32'h0,         32'h0,         4'b0000, 0, 0);
    addv(CBNZ,  0, 32'h0,         32'h5,         32'h0,         32'h0,         4'b0000, 1, 0);
    addv(CBZ,   0, 32'h0,         32'h3,         32'h0,         32'h0,         4'b0000, 0, 0);
    addv(4'b1000, 0, 32'h5,       32'h6,         32'h0,         32'h0,         4'b0000, 0, 1);
    addv(4'b0000, 0, 32'h5,       32'h6,         32'h0,         32'h0,         4'b0000, 0, 1);
    addv(MUL,   0, 32'h0001_0000, 32'h0001_0003, 32'h0,         32'h0003_0000, 4'b0000, 0, 0);
    addv(MUL,   0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         4'b0000, 0, 0);
    addv(ADD,   0, 32'h3,         32'h4,         32'h0,         32'h7,         4'b0000, 0, 0);
    addv(MUL,   1, 32'h0,         32'h5,         32'h12345,     32'h0,         4'b0100, 0, 0);

    prev_mul = 0;
    foreach (vq[i]) begin
      e = ref_alu(vq[i].c, vq[i].a, vq[i].s ? vq[i].im : vq[i].b);
      chk($sformatf("model_v%0d", i), {e.res, e.fl, e.br, e.err},
          {vq[i].res, vq[i].fl, vq[i].br, vq[i].err});
      send(vq[i].c, vq[i].s, vq[i].a, vq[i].b, vq[i].im, w);
      if (!prev_mul) chk($sformatf("throughput_v%0d", i), w, 0);
      prev_mul = (vq[i].c == MUL);
    end

    // MUL latency and BUSY back-pressure on the input side
    send(MUL, 1'b0, 32'h0001_0000, 32'h0001_0003, 32'h0, w);
    k = 0;
    while (!out_valid && k < 100) begin
      chk("mul_busy_in_ready", in_ready, 0);
      @(posedge clk); #1;
      k++;
    end
    chk("mul_latency_edges", k, 33);
    chk("mul_result", result, 32'h0003_0000);
    chk("mul_flags", flags, 4'b0000);
    @(posedge clk); #1;

    // Output back-pressure, then drain and accept in the same cycle
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    send(ADD, 1'b0, 32'd3, 32'd4, 32'h0, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_result", result, 32'd7);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(AND_, 1'b0, 32'h0000_00F0, 32'h0000_003C, 32'h0, w);
    chk("bp_same_cycle_accept", w, 0);
    chk("bp_and_result", result, 32'h0000_0030);

    // Reset during MUL iteration
    send(MUL, 1'b0, 32'h0001_0000, 32'h0001_0003, 32'h0, w);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    expq.delete();
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_result", result, 0);
    chk("midrst_flags", flags, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_stale_result", seen, 0);

    // Recovery after the aborted MUL
    @(posedge clk); #1;
    send(LSL, 1'b0, 32'h1, 32'd31, 32'h0, w);
    chk("post_rst_lsl_result", result, 32'h8000_0000);
    chk("post_rst_lsl_carry", flags[1], 0);
    repeat (3) @(posedge clk);
    chk("queue_drained", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
